// File: rtl/dmem_ctrl.sv
// ============================================================================
// dmem_ctrl - byte-addressable data memory with byte/half/word access and fault detection
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_ctrl #(
   parameter int DEPTH    = 1024,
   parameter int WORD_LEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [1:0]          size_i,
   input  logic                uns_i,
   input  logic [WORD_LEN-1:0] addr_i,
   input  logic [WORD_LEN-1:0] wdata_i,
   output logic                ready_o,
   output logic [WORD_LEN-1:0] rdata_o,
   output logic                err_o
);

   localparam int         c_aw      = $clog2(DEPTH);
   localparam logic [1:0] c_sz_byte = 2'b00;
   localparam logic [1:0] c_sz_half = 2'b01;
   localparam logic [1:0] c_sz_word = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [c_aw+1:0]     addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [WORD_LEN-1:0] rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [31:0]         mem_q [DEPTH];

   logic                w_illegal;
   logic [31:0]         w_rd_word;
   logic [7:0]          w_ld_byte;
   logic [15:0]         w_ld_half;
   logic [WORD_LEN-1:0] w_ld_val;
   logic [3:0]          w_wr_be;
   logic [31:0]         w_wr_word;

   // Request legality is judged on the live inputs so a fault skips ACCESS.
   always_comb begin
      w_illegal = 1'b0;
      case (size_i)
         c_sz_byte: w_illegal = 1'b0;
         c_sz_half: w_illegal = addr_i[0];
         c_sz_word: w_illegal = |addr_i[1:0];
         default:   w_illegal = 1'b1;
      endcase
      if (|addr_i[WORD_LEN-1:c_aw+2]) begin
         w_illegal = 1'b1;
      end
   end

   always_comb begin
      w_rd_word = mem_q[addr_q[c_aw+1:2]];
      w_ld_byte = w_rd_word[{addr_q[1:0], 3'b000} +: 8];
      w_ld_half = w_rd_word[{addr_q[1], 4'b0000} +: 16];
      w_ld_val  = WORD_LEN'(w_rd_word);
      w_wr_be   = 4'b1111;
      w_wr_word = wdata_q;
      case (size_q)
         c_sz_byte: begin
            w_ld_val  = uns_q ? WORD_LEN'(w_ld_byte) : WORD_LEN'($signed(w_ld_byte));
            w_wr_be   = 4'b0001 << addr_q[1:0];
            w_wr_word = {4{wdata_q[7:0]}};
         end
         c_sz_half: begin
            w_ld_val  = uns_q ? WORD_LEN'(w_ld_half) : WORD_LEN'($signed(w_ld_half));
            w_wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            w_wr_word = {2{wdata_q[15:0]}};
         end
         default: begin
            w_ld_val  = WORD_LEN'(w_rd_word);
            w_wr_be   = 4'b1111;
            w_wr_word = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               size_d  = size_i;
               uns_d   = uns_i;
               addr_d  = addr_i[c_aw+1:0];
               wdata_d = wdata_i[31:0];
               if (w_illegal) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = we_q ? '0 : w_ld_val;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // No reset on storage; an async reset pulls state_q out of ACCESS before the write edge.
   always_ff @(posedge clk) begin
      if (state_q == ACCESS && we_q) begin
         for (int i = 0; i < 4; i++) begin
            if (w_wr_be[i]) begin
               mem_q[addr_q[c_aw+1:2]][8*i +: 8] <= w_wr_word[8*i +: 8];
            end
         end
      end
   end

   assign ready_o = (state_q == RESP);
   assign rdata_o = rdata_q;
   assign err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// tb_dmem_ctrl - table-driven self-checking bench for dmem_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

   localparam int DEPTH = 1024;

   logic        clk;
   logic        rst_n;
   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        uns_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        ready_o;
   logic [31:0] rdata_o;
   logic        err_o;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_ctrl #(.DEPTH(DEPTH), .WORD_LEN(32)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (req_i),
      .we_i    (we_i),
      .size_i  (size_i),
      .uns_i   (uns_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .ready_o (ready_o),
      .rdata_o (rdata_o),
      .err_o   (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic err, input logic [31:0] rdata);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.err = err; v.rdata = rdata;
      tbl.push_back(v);
   endtask

   task automatic launch(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
      req_i = 1'b1; we_i = we; size_i = size; uns_i = uns; addr_i = addr; wdata_i = wdata;
   endtask

   // Waits for the response after the sampling edge; latency counts edges until ready is seen.
   task automatic finish_txn(input string name, input logic exp_err, input logic [31:0] exp_rd);
      int lat;
      int exp_lat;
      exp_lat = exp_err ? 1 : 2;
      @(posedge clk); #1;
      req_i = 1'b0;
      lat = 1;
      while (!ready_o && lat < 6) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_ready"}, 32'(ready_o), 32'd1);
      chk({name, "_lat"},   32'(lat),     32'(exp_lat));
      chk({name, "_err"},   32'(err_o),   32'(exp_err));
      chk({name, "_rdata"}, rdata_o,      exp_rd);
      @(posedge clk); #1;
      chk({name, "_pulse"}, 32'(ready_o), 32'd0);
      chk({name, "_hold"},  rdata_o,      exp_rd);
   endtask

   initial begin
      rst_n = 1'b0;
      req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; uns_i = 1'b0; addr_i = '0; wdata_i = '0;

      //   we    size   uns   addr          wdata          err   rdata
      add(1'b1, 2'b10, 1'b0, 32'h10,       32'h12345678,  1'b0, 32'h0);
      add(1'b0, 2'b10, 1'b0, 32'h10,       32'h0,         1'b0, 32'h12345678);
      add(1'b1, 2'b00, 1'b0, 32'h11,       32'hFFFFFFAB,  1'b0, 32'h0);
      add(1'b0, 2'b10, 1'b0, 32'h10,       32'h0,         1'b0, 32'h1234AB78);
      add(1'b0, 2'b00, 1'b0, 32'h11,       32'h0,         1'b0, 32'hFFFFFFAB);
      add(1'b0, 2'b00, 1'b1, 32'h11,       32'h0,         1'b0, 32'h000000AB);
      add(1'b1, 2'b01, 1'b0, 32'h12,       32'hFFFF8001,  1'b0, 32'h0);
      add(1'b0, 2'b01, 1'b0, 32'h12,       32'h0,         1'b0, 32'hFFFF8001);
      add(1'b0, 2'b01, 1'b1, 32'h12,       32'h0,         1'b0, 32'h00008001);
      add(1'b0, 2'b10, 1'b0, 32'h10,       32'h0,         1'b0, 32'h8001AB78);
      add(1'b0, 2'b00, 1'b0, 32'h13,       32'h0,         1'b0, 32'hFFFFFF80);
      add(1'b0, 2'b00, 1'b0, 32'h12,       32'h0,         1'b0, 32'h00000001);
      add(1'b0, 2'b01, 1'b0, 32'h10,       32'h0,         1'b0, 32'hFFFFAB78);
      add(1'b0, 2'b00, 1'b1, 32'h10,       32'h0,         1'b0, 32'h00000078);
      add(1'b1, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D,  1'b0, 32'h0);
      add(1'b1, 2'b10, 1'b0, 32'h20,       32'h0,         1'b0, 32'h0);
      add(1'b1, 2'b00, 1'b0, 32'h23,       32'h00000055,  1'b0, 32'h0);
      add(1'b0, 2'b10, 1'b1, 32'h20,       32'h0,         1'b0, 32'h55000000);
      add(1'b1, 2'b10, 1'b0, 32'h20,       32'h0,         1'b0, 32'h0);
      add(1'b0, 2'b10, 1'b0, 32'h2,        32'h0,         1'b1, 32'h0);
      add(1'b1, 2'b01, 1'b0, 32'h1,        32'hFFFF,      1'b1, 32'h0);
      add(1'b1, 2'b11, 1'b0, 32'h0,        32'h0,         1'b1, 32'h0);
      add(1'b1, 2'b10, 1'b0, 32'(DEPTH*4), 32'h11111111,  1'b1, 32'h0);
      add(1'b0, 2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 32'hCAFEF00D);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_err",   32'(err_o),   32'd0);
      chk("rst_rdata", rdata_o,      32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         launch(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata);
         finish_txn($sformatf("v%0d", i), tbl[i].err, tbl[i].rdata);
      end

      // Reset during ACCESS of a store: the write must never land.
      @(negedge clk);
      launch(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
      @(posedge clk); #1;
      req_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_ready", 32'(ready_o), 32'd0);
      chk("abort_err",   32'(err_o),   32'd0);
      chk("abort_rdata", rdata_o,      32'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("abort_noready%0d", k), 32'(ready_o), 32'd0);
      end

      // First request is sampled on the first edge after reset release.
      @(negedge clk);
      rst_n = 1'b1;
      launch(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      finish_txn("post_rst_lw", 1'b0, 32'h0);

      // Continuous req: a response every third cycle, never back to back.
      @(negedge clk);
      launch(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk($sformatf("b2b_ready%0d", k), 32'(ready_o), (k % 3 == 1) ? 32'd1 : 32'd0);
         if (k % 3 == 1) begin
            chk($sformatf("b2b_rdata%0d", k), rdata_o, 32'hCAFEF00D);
         end
      end
      req_i = 1'b0;
      repeat (4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
